// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: pixel divider decode,
// timing total / sync-start helpers and the default counter width.
package video_timing_pkg;

    localparam int CNT_WIDTH_DEF = 10;

    // ce_divider encoding used by the video pipeline: 0 selects /4, n selects /(n+1).
    function automatic logic [3:0] ce_div_decode(input logic [2:0] ce_divider);
        return (ce_divider == 3'd0) ? 4'd4 : ({1'b0, ce_divider} + 4'd1);
    endfunction

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable generator. ce_fire is the combinational "strobe on the
// next edge" used by the counters; ce_pix is its registered copy so the
// strobe lines up with the counter update it causes.
module pix_ce_gen
    import video_timing_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [2:0] ce_divider,
    output logic       ce_fire,
    output logic       ce_pix
);

    logic [2:0] cnt_q, cnt_d;
    logic [3:0] div_last;
    logic       ce_pix_q;

    // Compare with >= so a divider lowered below the current count fires at once.
    always_comb begin
        div_last = ce_div_decode(ce_divider) - 4'd1;
        ce_fire  = ({1'b0, cnt_q} >= div_last);
        cnt_d    = ce_fire ? 3'd0 : (cnt_q + 3'd1);
    end

    // Divider count and registered strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q    <= 3'd0;
            ce_pix_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ce_pix_q <= ce_fire;
        end
    end

    assign ce_pix = ce_pix_q;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel strobe, H/V counters and sync/blank/DE flags.
// Optional feature macro VIDEO_TIMING_INTERLACE_EN adds the interlace input and
// field output; field-1 frames get one extra line and half-line VSync edges.
// Flags are decoded from the next-state counts so they change in the same
// cycle as hcount/vcount.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = 256,
    parameter int   H_FP      = 8,
    parameter int   H_SYNC    = 32,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 224,
    parameter int   V_FP      = 8,
    parameter int   V_SYNC    = 3,
    parameter int   V_BP      = 27,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [2:0]           ce_divider,
    output logic                 ce_pix,
    output logic [CNT_WIDTH-1:0] hcount,
    output logic [CNT_WIDTH-1:0] vcount,
    output logic                 HSync,
    output logic                 VSync,
    output logic                 HBlank,
    output logic                 VBlank,
    output logic                 DE,
    output logic                 line_start,
    output logic                 frame_start
`ifdef VIDEO_TIMING_INTERLACE_EN
    ,
    input  logic                 interlace,
    output logic                 field
`endif
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = sync_start(H_ACTIVE, H_FP);
    localparam int VS_BEG  = sync_start(V_ACTIVE, V_FP);

    localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] H_LAST_C   = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_ACT_C    = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] H_HALF_C   = CNT_WIDTH'(H_TOTAL / 2);
    localparam logic [CNT_WIDTH-1:0] HS_START_C = CNT_WIDTH'(HS_BEG);
    localparam logic [CNT_WIDTH-1:0] HS_END_C   = CNT_WIDTH'(HS_BEG + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_LAST_C   = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_ACT_C    = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] VS_START_C = CNT_WIDTH'(VS_BEG);
    localparam logic [CNT_WIDTH-1:0] VS_END_C   = CNT_WIDTH'(VS_BEG + V_SYNC);

    logic                 ce_fire;
    logic [CNT_WIDTH-1:0] h_q, h_d, v_q, v_d, v_last;
    logic                 hsync_q, vsync_q, hblank_q, vblank_q, de_q;
    logic                 line_start_q, frame_start_q;
    logic                 hs_act, vs_act;
    logic                 field_d;

    pix_ce_gen u_pix_ce_gen (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce_divider (ce_divider),
        .ce_fire    (ce_fire),
        .ce_pix     (ce_pix)
    );

`ifdef VIDEO_TIMING_INTERLACE_EN
    localparam logic [CNT_WIDTH-1:0] V_LAST_EXT_C = CNT_WIDTH'(V_TOTAL);
    logic field_q;

    // Field-1 frames carry the extra line at the end of the back porch.
    always_comb begin
        v_last = field_q ? V_LAST_EXT_C : V_LAST_C;
    end

    // Field register; interlace only matters at the frame wrap.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            field_q <= 1'b0;
        end else begin
            field_q <= field_d;
        end
    end

    assign field = field_q;
`else
    assign v_last  = V_LAST_C;
    assign field_d = 1'b0;
`endif

    // Next-state pixel/line position, advancing only on the pixel strobe.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
`ifdef VIDEO_TIMING_INTERLACE_EN
        field_d = field_q;
`endif
        if (ce_fire) begin
            if (h_q == H_LAST_C) begin
                h_d = '0;
                if (v_q == v_last) begin
                    v_d = '0;
`ifdef VIDEO_TIMING_INTERLACE_EN
                    field_d = interlace ? ~field_q : 1'b0;
`endif
                end else begin
                    v_d = v_q + ONE_C;
                end
            end else begin
                h_d = h_q + ONE_C;
            end
        end
    end

    // Sync windows from the next-state position; field-1 VSync is shifted by half a line.
    always_comb begin
        hs_act = (h_d >= HS_START_C) && (h_d < HS_END_C);
        if (field_d) begin
            vs_act = ((v_d > VS_START_C) || ((v_d == VS_START_C) && (h_d >= H_HALF_C))) &&
                     ((v_d < VS_END_C)   || ((v_d == VS_END_C)   && (h_d <  H_HALF_C)));
        end else begin
            vs_act = (v_d >= VS_START_C) && (v_d < VS_END_C);
        end
    end

    // Counters and all registered flag outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hs_act ? HS_POL : ~HS_POL;
            vsync_q       <= vs_act ? VS_POL : ~VS_POL;
            hblank_q      <= (h_d >= H_ACT_C);
            vblank_q      <= (v_d >= V_ACT_C);
            de_q          <= (h_d < H_ACT_C) && (v_d < V_ACT_C);
            line_start_q  <= ce_fire && (h_d == '0);
            frame_start_q <= ce_fire && (h_d == '0) && (v_d == '0);
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign DE          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen with a small 14x7 raster.
// Reference model tracks the linear pixel index within the frame and the
// clocks elapsed since the last pixel strobe.
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int CW  = 4;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [2:0]    ce_divider;
    logic          ce_pix;
    logic [CW-1:0] hcount, vcount;
    logic          HSync, VSync, HBlank, VBlank, DE, line_start, frame_start;
    bit            ilace_in = 1'b0;

`ifdef VIDEO_TIMING_INTERLACE_EN
    logic interlace, field;
    assign interlace = ilace_in;
`endif

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (1'b0), .VS_POL (1'b0), .CNT_WIDTH (CW)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_divider  (ce_divider),
        .ce_pix      (ce_pix),
        .hcount      (hcount),
        .vcount      (vcount),
        .HSync       (HSync),
        .VSync       (VSync),
        .HBlank      (HBlank),
        .VBlank      (VBlank),
        .DE          (DE),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VIDEO_TIMING_INTERLACE_EN
        ,
        .interlace   (interlace),
        .field       (field)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int since, fpix, flen;
    bit fld, m_ce, m_ls, m_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [2:0] d);
        return (d == 3'd0) ? 4 : int'(d) + 1;
    endfunction

    task automatic model_reset();
        since = 0; fpix = 0; fld = 1'b0; flen = HT * VT;
        m_ce = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step();
        m_ce = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
        since++;
        if (since >= div_of(ce_divider)) begin
            since = 0;
            m_ce  = 1'b1;
            fpix++;
            if (fpix == flen) begin
                fpix = 0;
                fld  = ilace_in ? ~fld : 1'b0;
                flen = fld ? HT * (VT + 1) : HT * VT;
            end
            m_ls = (fpix % HT == 0);
            m_fs = (fpix == 0);
        end
    endtask

    task automatic check_all();
        int h, v;
        bit hs_on, vs_on;
        h = fpix % HT;
        v = fpix / HT;
        hs_on = (h >= HA + HFP) && (h < HA + HFP + HSW);
        if (fld) vs_on = (fpix >= (VA + VFP) * HT + HT / 2) && (fpix < (VA + VFP + VSW) * HT + HT / 2);
        else     vs_on = (fpix >= (VA + VFP) * HT) && (fpix < (VA + VFP + VSW) * HT);
        check("ce_pix",      32'(ce_pix),      32'(m_ce));
        check("hcount",      32'(hcount),      32'(h));
        check("vcount",      32'(vcount),      32'(v));
        check("HBlank",      32'(HBlank),      32'(h >= HA));
        check("VBlank",      32'(VBlank),      32'(v >= VA));
        check("DE",          32'(DE),          32'((h < HA) && (v < VA)));
        check("HSync",       32'(HSync),       32'(!hs_on));
        check("VSync",       32'(VSync),       32'(!vs_on));
        check("line_start",  32'(line_start),  32'(m_ls));
        check("frame_start", 32'(frame_start), 32'(m_fs));
`ifdef VIDEO_TIMING_INTERLACE_EN
        check("field",       32'(field),       32'(fld));
`endif
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            if (!reset) model_step();
            #1;
            check_all();
        end
    endtask

    // async assert checked before any edge, held across one edge, released away from the edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_sys);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic wait_ce(input int bound, output int gap);
        gap = -1;
        for (int i = 1; i <= bound; i++) begin
            run_cycles(1);
            if (ce_pix) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic frame_stats(input int nframes, input bit ilace);
        int fs_seen, ce_cnt, de_cnt, ln_ce, ls_seen, cyc, exp_len;
        logic pv, ph, phs;
        fs_seen = 0; ce_cnt = 0; de_cnt = 0; ln_ce = 0; ls_seen = 0; cyc = 0;
        pv = VSync; ph = HBlank; phs = HSync;
        while (fs_seen <= nframes && cyc < 4000) begin
            run_cycles(1);
            cyc++;
            if (ce_pix) begin
                if (frame_start) begin
                    if (fs_seen > 0) begin
                        exp_len = (ilace && (fs_seen % 2 == 1)) ? HT * (VT + 1) : HT * VT;
                        check("frame_len", 32'(ce_cnt), 32'(exp_len));
                        check("frame_de",  32'(de_cnt), 32'(HA * VA));
                    end
                    ce_cnt = 0; de_cnt = 0; fs_seen++;
                end
                if (line_start) begin
                    if (ls_seen > 0 && ls_seen < 8) check("line_len", 32'(ln_ce), 32'(HT));
                    ln_ce = 0; ls_seen++;
                end
                ce_cnt++; ln_ce++;
                if (DE) de_cnt++;
            end
            if (HBlank && !ph) check("hblank_rise_h", 32'(hcount), 32'(HA));
            if (!HSync && phs) check("hsync_on_h",    32'(hcount), 32'(HA + HFP));
            if (HSync && !phs) check("hsync_off_h",   32'(hcount), 32'(HA + HFP + HSW));
            if (VSync != pv)   check("vsync_edge_h",  32'(hcount), 32'(fld ? HT / 2 : 0));
            pv = VSync; ph = HBlank; phs = HSync;
        end
        check("frame_stats_done", 32'(cyc < 4000), 32'd1);
    endtask

    typedef struct {
        logic [2:0] div;
        int         first_gap;
        int         next_gap;
    } div_vec_t;

    div_vec_t vecs[8];
    int       gap;
    int       cyc;

    initial begin
        vecs[0] = '{3'd0, 4, 4};
        vecs[1] = '{3'd1, 2, 2};
        vecs[2] = '{3'd2, 3, 3};
        vecs[3] = '{3'd3, 4, 4};
        vecs[4] = '{3'd4, 5, 5};
        vecs[5] = '{3'd5, 6, 6};
        vecs[6] = '{3'd6, 7, 7};
        vecs[7] = '{3'd7, 8, 8};

        reset      = 1'b0;
        ce_divider = 3'd0;
        #2;

        // reset held for several clocks
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        run_cycles(3);
        reset = 1'b0;

        // divider table: first strobe latency after release and steady period
        for (int k = 0; k < 8; k++) begin
            ce_divider = vecs[k].div;
            do_reset();
            wait_ce(40, gap);
            check("first_ce_gap", 32'(gap), 32'(vecs[k].first_gap));
            wait_ce(40, gap);
            check("ce_period", 32'(gap), 32'(vecs[k].next_gap));
        end

        // divider 2 -> 1 with count at 2
        ce_divider = 3'd2;
        do_reset();
        wait_ce(40, gap);
        run_cycles(2);
        ce_divider = 3'd1;
        run_cycles(1);
        check("switch_2to1", 32'(ce_pix), 32'd1);

        // divider /4 -> /2 with count at 1: fires next clock, no double pulse
        ce_divider = 3'd0;
        wait_ce(40, gap);
        run_cycles(1);
        ce_divider = 3'd1;
        run_cycles(1);
        check("switch_0to1", 32'(ce_pix), 32'd1);
        run_cycles(1);
        check("switch_0to1_gap", 32'(ce_pix), 32'd0);
        run_cycles(1);
        check("switch_0to1_next", 32'(ce_pix), 32'd1);

        // /8 -> /5 with count at 2: keeps counting up to 4
        ce_divider = 3'd7;
        wait_ce(40, gap);
        run_cycles(2);
        ce_divider = 3'd4;
        wait_ce(40, gap);
        check("switch_7to4_gap", 32'(gap), 32'd3);

        // full line / frame statistics, progressive
        ce_divider = 3'd1;
        do_reset();
        frame_stats(3, 1'b0);

        // async reset in the middle of line 5 at pixel 9
        ce_divider = 3'd0;
        do_reset();
        cyc = 0;
        while (!(m_ce && fpix == 5 * HT + 9) && cyc < 3000) begin
            run_cycles(1);
            cyc++;
        end
        check("midline_h", 32'(hcount), 32'd9);
        check("midline_v", 32'(vcount), 32'd5);
        do_reset();
        check("midline_reset_h", 32'(hcount), 32'd0);
        check("midline_reset_hblank", 32'(HBlank), 32'd0);

`ifdef VIDEO_TIMING_INTERLACE_EN
        // interlaced: alternating 98/112 pixel frames, half-line VSync on field 1
        ce_divider = 3'd1;
        ilace_in   = 1'b1;
        do_reset();
        frame_stats(4, 1'b1);
        ilace_in   = 1'b0;
`endif

        // randomized divider (and interlace) changes against the model
        ce_divider = 3'($urandom_range(0, 7));
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) ce_divider = 3'($urandom_range(0, 7));
`ifdef VIDEO_TIMING_INTERLACE_EN
            if ($urandom_range(0, 299) == 0) ilace_in = ~ilace_in;
`endif
            if (c == 1500) do_reset();
            run_cycles(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
